btn_debounce: RTL and testbench



---
 rtl/btn_pkg.sv | 18 +
 rtl/btn_sync.sv | 26 ++
 rtl/btn_debounce.sv | 147 ++++++++++++++
 tb/tb_btn_debounce.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and constants for push-button conditioning.
// Timing helper converts milliseconds to clk cycles at the board clock rate.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } btn_state_t;

    localparam int CLK_HZ = 100_000_000;

    function automatic int ms_to_cycles(input int ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

endpackage

// File: rtl/btn_sync.sv
// N-flop synchroniser for an asynchronous single-bit input, reset to RST_VAL.
// Latency: N clk cycles. No backpressure.
// The first flop may go metastable; only the last stage is exported.
module btn_sync #(
    parameter int N       = 2,
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic n_rst,
    input  logic din,
    output logic dout
);

    logic [N-1:0] chain;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            chain <= {N{RST_VAL}};
        end else begin
            chain <= {chain[N-2:0], din};
        end
    end

    assign dout = chain[N-1];

endmodule

// File: rtl/btn_debounce.sv
// Push-button synchroniser + debouncer; clean level plus one-cycle press/release strobes.
// Latency: DEBOUNCE_CYCLES+3 clk from a steady pin change to the strobe. No backpressure.
// Optional auto-repeat of press_pulse while held: define BTN_REPEAT_EN.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = ms_to_cycles(10),
    parameter bit BTN_ACTIVE_LOW  = 1'b1,
    parameter int REPEAT_DELAY    = ms_to_cycles(500),
    parameter int REPEAT_PERIOD   = ms_to_cycles(100)
) (
    input  logic clk,
    input  logic n_rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse
);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("btn_debounce: DEBOUNCE_CYCLES must be at least 2");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("btn_debounce: REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
    end

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic       sync_out;
    logic       pressed;
    btn_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic       level_d, press_d, release_d;

    btn_sync #(
        .N       (2),
        .RST_VAL (BTN_ACTIVE_LOW)
    ) u_sync (
        .clk   (clk),
        .n_rst (n_rst),
        .din   (btn_raw),
        .dout  (sync_out)
    );

    assign pressed = sync_out ^ BTN_ACTIVE_LOW;

`ifdef BTN_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = $clog2(RPT_MAX + 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic          rpt_armed_q, rpt_armed_d;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rpt_cnt_q   <= '0;
            rpt_armed_q <= 1'b0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_armed_q <= rpt_armed_d;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = btn_level;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pressed) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!pressed) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PRESSED: begin
                if (!pressed) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (pressed) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef BTN_REPEAT_EN
        // Held at zero outside PRESSED, so every (re)entry restarts the initial delay.
        rpt_cnt_d   = rpt_cnt_q;
        rpt_armed_d = rpt_armed_q;
        if (state_q != PRESSED) begin
            rpt_cnt_d   = '0;
            rpt_armed_d = 1'b0;
        end else if (pressed) begin
            if (rpt_cnt_q == (rpt_armed_q ? PERIOD_LAST : DELAY_LAST)) begin
                press_d     = 1'b1;
                rpt_cnt_d   = '0;
                rpt_armed_d = 1'b1;
            end else begin
                rpt_cnt_d = rpt_cnt_q + RW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            btn_level     <= level_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
        end
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DEBOUNCE_CYCLES=8, active-low button,
// REPEAT_DELAY=20, REPEAT_PERIOD=5.
module tb_btn_debounce;

    logic clk;
    logic n_rst;
    logic btn_raw;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;

    int total   = 0;
    int bad     = 0;
    int overlap = 0;
    int pc, pf, pl, rc, rf;

    btn_debounce #(
        .DEBOUNCE_CYCLES (8),
        .BTN_ACTIVE_LOW  (1'b1),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (5)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .btn_raw       (btn_raw),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Runs n edges, sampling 1 ns after each; edge indices are 1-based from the call.
    task automatic run_watch(input int n, output int p_cnt, output int p_first,
                             output int p_last, output int r_cnt, output int r_first);
        p_cnt = 0; p_first = -1; p_last = -1; r_cnt = 0; r_first = -1;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            if (press_pulse === 1'b1) begin
                p_cnt++;
                if (p_first < 0) p_first = i;
                p_last = i;
            end
            if (release_pulse === 1'b1) begin
                r_cnt++;
                if (r_first < 0) r_first = i;
            end
            if (press_pulse === 1'b1 && release_pulse === 1'b1) overlap++;
        end
    endtask

    initial begin
        // 1: reset with button released
        n_rst   = 1'b0;
        btn_raw = 1'b1;
        #23;
        chk("rst_level", int'(btn_level), 0);
        chk("rst_press", int'(press_pulse), 0);
        chk("rst_release", int'(release_pulse), 0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        run_watch(100, pc, pf, pl, rc, rf);
        chk("idle_press_cnt", pc, 0);
        chk("idle_release_cnt", rc, 0);
        chk("idle_level", int'(btn_level), 0);

        // 2: clean press
        btn_raw = 1'b0;
        run_watch(20, pc, pf, pl, rc, rf);
        chk("press_cnt", pc, 1);
        chk("press_edge", pf, 11);
        chk("press_rel_cnt", rc, 0);
        chk("press_level", int'(btn_level), 1);

        // 4a: clean release
        btn_raw = 1'b1;
        run_watch(20, pc, pf, pl, rc, rf);
        chk("release_cnt", rc, 1);
        chk("release_edge", rf, 11);
        chk("release_press_cnt", pc, 0);
        chk("release_level", int'(btn_level), 0);

        // 3: bouncing press, then settle low
        for (int k = 0; k < 4; k++) begin
            btn_raw = (k % 2 == 0) ? 1'b0 : 1'b1;
            run_watch(3, pc, pf, pl, rc, rf);
            chk("bounce_press_cnt", pc, 0);
            chk("bounce_level", int'(btn_level), 0);
        end
        btn_raw = 1'b0;
        run_watch(20, pc, pf, pl, rc, rf);
        chk("bounce_settle_cnt", pc, 1);
        chk("bounce_settle_edge", pf, 11);
        chk("bounce_settle_level", int'(btn_level), 1);

        // 4b: 4-cycle release glitch is rejected
        btn_raw = 1'b1;
        run_watch(4, pc, pf, pl, rc, rf);
        chk("glitch_rel_a", rc, 0);
        btn_raw = 1'b0;
        run_watch(20, pc, pf, pl, rc, rf);
        chk("glitch_rel_b", rc, 0);
        chk("glitch_press", pc, 0);
        chk("glitch_level", int'(btn_level), 1);

        btn_raw = 1'b1;
        run_watch(20, pc, pf, pl, rc, rf);
        chk("release2_edge", rf, 11);
        chk("release2_level", int'(btn_level), 0);

        // 5: reset in the middle of PRESS_WAIT
        btn_raw = 1'b0;
        run_watch(8, pc, pf, pl, rc, rf);
        chk("midrst_pre_press", pc, 0);
        n_rst = 1'b0;
        #2;
        chk("midrst_level", int'(btn_level), 0);
        run_watch(4, pc, pf, pl, rc, rf);
        chk("midrst_hold_press", pc, 0);
        chk("midrst_hold_level", int'(btn_level), 0);
        n_rst = 1'b1;
        run_watch(20, pc, pf, pl, rc, rf);
        chk("midrst_press_cnt", pc, 1);
        chk("midrst_press_edge", pf, 11);
        chk("midrst_level_after", int'(btn_level), 1);

        btn_raw = 1'b1;
        run_watch(20, pc, pf, pl, rc, rf);
        chk("release3_edge", rf, 11);

        // 6: long hold, 60 cycles past acceptance
        btn_raw = 1'b0;
        run_watch(71, pc, pf, pl, rc, rf);
        chk("hold_first", pf, 11);
        chk("hold_rel_cnt", rc, 0);
`ifdef BTN_REPEAT_EN
        chk("hold_press_cnt", pc, 10);
        chk("hold_last", pl, 71);
`else
        chk("hold_press_cnt", pc, 1);
        chk("hold_last", pl, 11);
`endif
        chk("hold_level", int'(btn_level), 1);

        chk("no_overlap", overlap, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
